push_pop_sequencer: RTL and testbench

// Multi-cycle sequencer for Thumb PUSH/POP. While busy it owns the register_file

---
 rtl/push_pop_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_push_pop_sequencer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/push_pop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : push_pop_sequencer
// Desc     : Multi-cycle Thumb PUSH/POP sequencer driving register file and
//            data memory; optional SP alignment fault via SP_ALIGN_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module push_pop_sequencer #(
  parameter int DATA_W    = 32,
  parameter int REGLIST_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_pop,
  input  logic [REGLIST_W-1:0] reg_list,
  input  logic                 extra_reg,
  input  logic [DATA_W-1:0]    sp_value,
  input  logic [DATA_W-1:0]    reg_data,
  input  logic                 mem_ready,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic [3:0]           regA_select,
  output logic [3:0]           regB_select,
  output logic [3:0]           write_dest,
  output logic                 write_en,
  output logic [DATA_W-1:0]    write_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [DATA_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 busy,
  output logic                 pc_hold,
  output logic                 done,
  output logic                 fault
);

  localparam int CNT_W = $clog2(REGLIST_W + 2);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_CALC  = 2'd1;
  localparam logic [1:0] c_ST_XFER  = 2'd2;
  localparam logic [1:0] c_ST_WB_SP = 2'd3;

  localparam logic [3:0] c_REG_SP = 4'b1000;
  localparam logic [3:0] c_REG_PC = 4'b1001;
  localparam logic [3:0] c_REG_LR = 4'b1010;

  logic [1:0]           r_state;
  logic [1:0]           w_next_state;
  logic                 r_pop;
  logic                 r_extra;
  logic                 r_done;
  logic                 r_fault;
  logic [REGLIST_W-1:0] r_list;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_n;
  logic [DATA_W-3:0]    r_ptr_word;
  logic [DATA_W-1:0]    r_sp_new;
  logic [DATA_W-1:0]    w_n_bytes;
  logic [DATA_W-1:0]    w_base;
  logic [3:0]           w_cur_reg;
  logic                 w_align_fault;
  logic                 w_last;
  logic                 w_empty;

  // Transfer count from the latched operands (valid in CALC)
  always_comb begin
    w_n = CNT_W'(r_extra);
    for (int i = 0; i < REGLIST_W; i++) begin
      w_n = w_n + CNT_W'(r_list[i]);
    end
  end

  assign w_n_bytes = DATA_W'({w_n, 2'b00});
  assign w_base    = r_pop ? sp_value : (sp_value - w_n_bytes);
  assign w_last    = (r_cnt == CNT_W'(1));
  assign w_empty   = (w_n == '0);

`ifdef SP_ALIGN_CHECK_EN
  assign w_align_fault = (sp_value[1:0] != 2'b00);
`else
  assign w_align_fault = 1'b0;
`endif

  // Lowest pending list bit goes first; the extra register is always last
  always_comb begin
    w_cur_reg = r_pop ? c_REG_PC : c_REG_LR;
    for (int i = REGLIST_W - 1; i >= 0; i--) begin
      if (r_list[i]) begin
        w_cur_reg = 4'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE: begin
        if (start) begin
          w_next_state = c_ST_CALC;
        end
      end
      c_ST_CALC: begin
        if (w_align_fault || w_empty) begin
          w_next_state = c_ST_IDLE;
        end else begin
          w_next_state = c_ST_XFER;
        end
      end
      c_ST_XFER: begin
        if (mem_ready && w_last) begin
          w_next_state = c_ST_WB_SP;
        end
      end
      c_ST_WB_SP: begin
        w_next_state = c_ST_IDLE;
      end
      default: begin
        w_next_state = c_ST_IDLE;
      end
    endcase
  end

  always_comb begin
    regA_select = 4'b0000;
    regB_select = 4'b0000;
    write_dest  = 4'b0000;
    write_en    = 1'b0;
    write_data  = '0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    case (r_state)
      c_ST_CALC: begin
        regA_select = c_REG_SP;
      end
      c_ST_XFER: begin
        regA_select = c_REG_SP;
        mem_req     = 1'b1;
        mem_addr    = {r_ptr_word, 2'b00};
        if (!r_pop) begin
          mem_we      = 1'b1;
          regB_select = w_cur_reg;
          mem_wdata   = reg_data;
        end else if (mem_ready) begin
          write_en   = 1'b1;
          write_dest = w_cur_reg;
          write_data = mem_rdata;
        end
      end
      c_ST_WB_SP: begin
        regA_select = c_REG_SP;
        write_en    = 1'b1;
        write_dest  = c_REG_SP;
        write_data  = r_sp_new;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pop      <= 1'b0;
      r_extra    <= 1'b0;
      r_list     <= '0;
      r_cnt      <= '0;
      r_ptr_word <= '0;
      r_sp_new   <= '0;
      r_done     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          if (start) begin
            r_pop   <= is_pop;
            r_extra <= extra_reg;
            r_list  <= reg_list;
          end
        end
        c_ST_CALC: begin
          r_cnt      <= w_n;
          r_ptr_word <= w_base[DATA_W-1:2];
          r_sp_new   <= r_pop ? (sp_value + w_n_bytes) : (sp_value - w_n_bytes);
          if (w_align_fault || w_empty) begin
            r_done  <= 1'b1;
            r_fault <= w_align_fault;
          end
        end
        c_ST_XFER: begin
          if (mem_ready) begin
            r_ptr_word <= r_ptr_word + 1'b1;
            r_cnt      <= r_cnt - CNT_W'(1);
            if (r_list != '0) begin
              r_list <= r_list & (r_list - REGLIST_W'(1));
            end else begin
              r_extra <= 1'b0;
            end
          end
        end
        c_ST_WB_SP: begin
          r_done <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy    = (r_state != c_ST_IDLE);
  assign pc_hold = busy;
  assign done    = r_done;
  assign fault   = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_push_pop_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_push_pop_sequencer
// Desc     : Self-checking bench for push_pop_sequencer against a stack model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_push_pop_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_pop;
  logic [7:0]  reg_list;
  logic        extra_reg;
  logic [31:0] sp_value;
  logic [31:0] reg_data;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [3:0]  regA_select;
  logic [3:0]  regB_select;
  logic [3:0]  write_dest;
  logic        write_en;
  logic [31:0] write_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        busy;
  logic        pc_hold;
  logic        done;
  logic        fault;

  logic [31:0] rf      [16];
  logic [31:0] mem     [1024];
  logic [31:0] exp_rf  [16];
  logic [31:0] exp_mem [1024];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign sp_value  = rf[regA_select];
  assign reg_data  = rf[regB_select];
  assign mem_rdata = mem[mem_addr[11:2]];

  push_pop_sequencer #(.DATA_W(32), .REGLIST_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .is_pop(is_pop), .reg_list(reg_list),
    .extra_reg(extra_reg), .sp_value(sp_value), .reg_data(reg_data),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .regA_select(regA_select),
    .regB_select(regB_select), .write_dest(write_dest), .write_en(write_en),
    .write_data(write_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .pc_hold(pc_hold),
    .done(done), .fault(fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One PUSH/POP: model builds expected memory/register image, then the DUT is
  // run against a simple register file and memory while transfers are checked.
  task automatic run_op(input bit pop, input logic [7:0] list, input bit extra,
                        input logic [31:0] sp0, input int stall_pct, input int fixed_stalls);
    logic [3:0]  order[$];
    logic [31:0] base;
    logic [31:0] ea;
    int          n, k, cyc, stalls, stall_left, wr_seen, fault_seen, exp_wr, exp_lat, bad;
    bit          exp_fault, got_done;

    rf[8]     = sp0;
    exp_fault = 1'b0;
`ifdef SP_ALIGN_CHECK_EN
    exp_fault = (sp0[1:0] != 2'b00);
`endif
    for (int i = 0; i < 8; i++) if (list[i]) order.push_back(4'(i));
    if (extra) order.push_back(pop ? 4'd9 : 4'd10);
    if (exp_fault) order.delete();
    n    = order.size();
    base = pop ? sp0 : sp0 - 32'(4 * n);

    exp_rf  = rf;
    exp_mem = mem;
    for (int j = 0; j < n; j++) begin
      ea = base + 32'(4 * j);
      if (pop) exp_rf[order[j]] = mem[ea[11:2]];
      else     exp_mem[ea[11:2]] = rf[order[j]];
    end
    if (n > 0) exp_rf[8] = pop ? sp0 + 32'(4 * n) : sp0 - 32'(4 * n);
    exp_wr = (pop ? n : 0) + ((n > 0) ? 1 : 0);

    @(negedge clk);
    start     = 1'b1;
    is_pop    = pop;
    reg_list  = list;
    extra_reg = extra;
    mem_ready = 1'($urandom_range(1));
    k = 0; cyc = 0; stalls = 0; stall_left = fixed_stalls;
    wr_seen = 0; fault_seen = 0; got_done = 1'b0;

    while (!got_done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      // Garbage on the request inputs while busy must be ignored
      start     = 1'($urandom_range(1));
      is_pop    = 1'($urandom_range(1));
      reg_list  = 8'($urandom);
      extra_reg = 1'($urandom_range(1));
      if (stall_left > 0) mem_ready = 1'b0;
      else                mem_ready = ($urandom_range(99) >= stall_pct);
      #1;
      if (write_en) begin
        wr_seen++;
        if (mem_req) begin
          ea = base + 32'(4 * k);
          if (k < n) check("pop_dest", 32'(write_dest), 32'(order[k]));
          check("pop_data", write_data, mem[ea[11:2]]);
        end else begin
          check("wb_dest", 32'(write_dest), 32'd8);
          check("wb_after_xfers", 32'(k), 32'(n));
        end
        rf[write_dest] = write_data;
      end
      if (mem_req) begin
        if (k < n) begin
          ea = base + 32'(4 * k);
          ea[1:0] = 2'b00;
          check("mem_addr", mem_addr, ea);
          check("mem_we", 32'(mem_we), 32'(!pop));
          if (!pop) begin
            check("regB_select", 32'(regB_select), 32'(order[k]));
            check("mem_wdata", mem_wdata, rf[order[k]]);
          end
        end else begin
          check("unexpected_mem_req", 32'(mem_req), 32'd0);
        end
        if (mem_ready) begin
          if (mem_we) mem[mem_addr[11:2]] = mem_wdata;
          k++;
        end else begin
          stalls++;
          if (stall_left > 0) stall_left--;
        end
      end
      if (fault) fault_seen++;
      check("busy", 32'(busy), 32'(!done));
      check("pc_hold", 32'(pc_hold), 32'(busy));
      if (done) begin
        got_done = 1'b1;
        start    = 1'b0;
      end
    end

    exp_lat = (n == 0) ? 2 : n + 3 + stalls;
    check("done_seen", 32'(got_done), 32'd1);
    check("latency", 32'(cyc), 32'(exp_lat));
    check("xfers", 32'(k), 32'(n));
    check("writes", 32'(wr_seen), 32'(exp_wr));
    check("fault", 32'(fault_seen), 32'(exp_fault));
    for (int r = 0; r < 11; r++) check($sformatf("rf[%0d]", r), rf[r], exp_rf[r]);
    bad = 0;
    for (int w = 0; w < 1024; w++) if (mem[w] !== exp_mem[w]) bad++;
    check("mem_words_wrong", 32'(bad), 32'd0);
  endtask

  // Reset during the second transfer of PUSH {R0-R7}
  task automatic reset_mid_op();
    int wb_seen;
    wb_seen = 0;
    rf[8]   = 32'h200;
    @(negedge clk);
    start = 1'b1; is_pop = 1'b0; reg_list = 8'hFF; extra_reg = 1'b0; mem_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (write_en) wb_seen++;
    end
    check("rst_xfer2_addr", mem_addr, 32'h1E4);
    rst = 1'b1;
    @(negedge clk);
    #1;
    if (write_en) wb_seen++;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      if (write_en) wb_seen++;
    end
    check("rst_no_sp_write", 32'(wb_seen), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_pop = 1'b0; reg_list = '0; extra_reg = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) rf[i] = $urandom;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pc_hold", 32'(pc_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_write_en", 32'(write_en), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_write_data", write_data, 32'd0);
    check("rst_regA", 32'(regA_select), 32'd0);
    rst = 1'b0;

    run_op(1'b0, 8'b0000_0101, 1'b1, 32'h100, 0, 0);  // PUSH {R0,R2,LR}
    run_op(1'b1, 8'b0000_0010, 1'b1, 32'hF4,  0, 0);  // POP {R1,PC}
    run_op(1'b0, 8'h00,        1'b0, 32'h300, 0, 0);
    run_op(1'b1, 8'h00,        1'b0, 32'h300, 0, 0);
    run_op(1'b0, 8'b0000_1000, 1'b0, 32'h100, 0, 3);  // PUSH {R3} with stalls
    run_op(1'b0, 8'hFF,        1'b1, 32'h800, 20, 0);
    run_op(1'b1, 8'hFF,        1'b1, 32'h7DC, 20, 0);
    reset_mid_op();
    run_op(1'b0, 8'b1000_0001, 1'b0, 32'h400, 0, 0);
    run_op(1'b0, 8'b0000_0101, 1'b1, 32'h102, 0, 0);  // misaligned SP

    for (int t = 0; t < 40; t++) begin
      run_op(1'($urandom_range(1)), 8'($urandom), 1'($urandom_range(1)),
             32'h100 + 32'(4 * $urandom_range(0, 32'h300)), 30, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
